jtag_system_en_sync: RTL
========================

Name: jtag_system_en_sync

Overview:
Downstream consumer of the JTAG system-enable control port. Takes the raw cpu_en / system_reset levels, which are driven from the JTAG tck domain and are asynchronous to the system clock, plus an optional board reset request. Produces glitch-free, correctly ordered cpu_en and system_reset in the system clk domain. Ordering: CPUs are quiesced before reset asserts; reset is held a guaranteed minimum time; CPUs are re-enabled only after reset has released and settled.

Parameters:
SYNC_STAGES, 2, synchronizer flop depth per async input (>=2)
DRAIN_CYC, 8, cycles cpu_en is low before system_reset asserts (>=1)
RST_HOLD, 16, minimum cycles system_reset stays high (>=1)
RELEASE_WAIT, 4, cycles between system_reset falling and cpu_en rising (>=1)

Ports:
clk  input  1  system clock; only clock of the block
reset  input  1  synchronous, active-low block reset (0 = reset)
jtag_system_reset_i  input  1  async reset request from JTAG control port, active high
jtag_cpu_en_i  input  1  async CPU enable from JTAG control port, active high
ext_reset_req_i  input  1  synchronous board/soft reset request, active high
cpu_en  output  1  registered CPU enable, fans out to all cores
system_reset  output  1  registered system reset, active high
busy  output  1  registered; 1 whenever state != RUN

Behaviour:
- One clock: clk. Reset is synchronous and active-low: port reset, sampled on posedge clk, 0 = reset.
- Synchronizers: SYNC_STAGES flops per JTAG input. Reset values: reset chain = 1, cpu_en chain = 0.
- Internal signals: rst_req = sync(jtag_system_reset_i) | ext_reset_req_i; en_req = sync(jtag_cpu_en_i).
- All outputs are flops updated on the same edge as the state register; no combinational path from any input to any output.
- reset = 0: state=RST, cnt=RST_HOLD-1, system_reset=1, cpu_en=0, busy=1.
- State RUN:
  - system_reset=0, busy=0, cpu_en follows en_req with one-cycle register latency.
  - rst_req=1 -> DRAIN, cnt=DRAIN_CYC-1, cpu_en=0, busy=1.
- State DRAIN:
  - cpu_en=0, system_reset=0.
  - cnt decrements each cycle; at cnt==0 -> RST, cnt=RST_HOLD-1, system_reset=1.
  - rst_req dropping during DRAIN does not abort; the full sequence completes.
- State RST:
  - system_reset=1, cpu_en=0.
  - cnt decrements and saturates at 0.
  - Exit only when cnt==0 and rst_req==0 -> RELEASE, cnt=RELEASE_WAIT-1, system_reset=0.
  - rst_req held high keeps the block in RST indefinitely.
- State RELEASE:
  - system_reset=0, cpu_en=0.
  - rst_req=1 -> RST, cnt reload RST_HOLD-1; no DRAIN, CPUs are already off.
  - At cnt==0 with rst_req==0 -> RUN, cpu_en=en_req, busy=0.
- Simultaneous events: rst_req takes priority over counter expiry in every state.
- Latencies, input edge sampled at edge k:
  - cpu_en falls at k+SYNC_STAGES.
  - system_reset rises at k+SYNC_STAGES+DRAIN_CYC.
- Counter width: $clog2 of max(DRAIN_CYC, RST_HOLD, RELEASE_WAIT)+1. The counter never wraps.
- cpu_en and system_reset are never both 1.
- en_req toggling is ignored outside RUN.

Decomposition:
- Shared package: state encoding localparams (RUN, DRAIN, RST, RELEASE) and a counter-width function.
- One natural sub-module: sync_flop_chain (parameter depth, parameter reset value). Instantiate twice.

Test Plan:
- Power-on: hold reset=0 for 3 cycles, then release with all requests 0 -> system_reset stays 1 for 16 cycles after release, cpu_en rises 4 cycles after system_reset falls; en_req=0 keeps cpu_en at 0.
- JTAG reset pulse: with en_req=1 in RUN, raise jtag_system_reset_i 1 cycle before edge k and drop it at k+3 -> cpu_en=0 at k+2, system_reset=1 k+10..k+25, system_reset=0 at k+26, cpu_en=1 at k+30.
- Long hold: keep jtag_system_reset_i=1 for 100 cycles -> system_reset stays 1 until 2 cycles after release; cpu_en stays 0 throughout; busy=1 throughout.
- Re-request in RELEASE: assert ext_reset_req_i 2 cycles into RELEASE -> next edge system_reset=1, full 16-cycle hold, no DRAIN phase; cpu_en never rises.
- Mid-sequence block reset: drive reset=0 during DRAIN -> next edge state RST, system_reset=1, cpu_en=0, counter reloaded to 15.
- Enable toggle: in RUN toggle jtag_cpu_en_i -> cpu_en follows 2 cycles later; system_reset stays 0; a toggle during RST has no effect on cpu_en.

Source files
------------

// File: rtl/jtag_system_en_sync_pkg.sv
// Shared state encoding and counter sizing for the JTAG system-enable synchronizer.
package jtag_system_en_sync_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_RST     = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   // Width needed to hold the largest reload value without wrapping.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/jtag_system_en_sync_sync_flop_chain.sv
// Plain multi-flop synchronizer with a configurable reset value.
module sync_flop_chain #(
   parameter int   DEPTH   = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] chain;

   always_ff @(posedge clk) begin
      if (!reset) chain <= {DEPTH{RST_VAL}};
      else        chain <= {chain[DEPTH-2:0], d};
   end

   assign q = chain[DEPTH-1];

endmodule

// File: rtl/jtag_system_en_sync.sv
// Orders cpu_en / system_reset from the JTAG control port into the system clock domain.
//  state      | meaning
//  ST_RUN     | normal operation, cpu_en follows en_req
//  ST_DRAIN   | CPUs quiesced, waiting DRAIN_CYC before asserting reset
//  ST_RST     | system_reset high, held at least RST_HOLD and while rst_req
//  ST_RELEASE | reset released, settling RELEASE_WAIT before re-enabling CPUs
module jtag_system_en_sync
   import jtag_system_en_sync_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int DRAIN_CYC    = 8,
   parameter int RST_HOLD     = 16,
   parameter int RELEASE_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic jtag_system_reset_i,
   input  logic jtag_cpu_en_i,
   input  logic ext_reset_req_i,
   output logic cpu_en,
   output logic system_reset,
   output logic busy
);

   localparam int CW = cnt_width(DRAIN_CYC, RST_HOLD, RELEASE_WAIT);
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYC - 1);
   localparam logic [CW-1:0] HOLD_LOAD  = CW'(RST_HOLD - 1);
   localparam logic [CW-1:0] WAIT_LOAD  = CW'(RELEASE_WAIT - 1);

   logic jtag_rst_sync, en_req, rst_req;
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic cpu_en_nxt, system_reset_nxt, busy_nxt;

   // Reset request chain powers up asserted so a fresh block never runs on garbage.
   sync_flop_chain #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rst (
      .clk   (clk),
      .reset (reset),
      .d     (jtag_system_reset_i),
      .q     (jtag_rst_sync)
   );

   sync_flop_chain #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_en (
      .clk   (clk),
      .reset (reset),
      .d     (jtag_cpu_en_i),
      .q     (en_req)
   );

   assign rst_req = jtag_rst_sync | ext_reset_req_i;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_RUN: begin
            if (rst_req) begin
               state_nxt = ST_DRAIN;
               cnt_nxt   = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            if (cnt == '0) begin
               state_nxt = ST_RST;
               cnt_nxt   = HOLD_LOAD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_RST: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else if (!rst_req) begin
               state_nxt = ST_RELEASE;
               cnt_nxt   = WAIT_LOAD;
            end
         end
         ST_RELEASE: begin
            // CPUs are already off, so a new request skips straight back to reset.
            if (rst_req) begin
               state_nxt = ST_RST;
               cnt_nxt   = HOLD_LOAD;
            end else if (cnt == '0) begin
               state_nxt = ST_RUN;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = ST_RST;
            cnt_nxt   = HOLD_LOAD;
         end
      endcase
      cpu_en_nxt       = (state_nxt == ST_RUN) & en_req;
      system_reset_nxt = (state_nxt == ST_RST);
      busy_nxt         = (state_nxt != ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= ST_RST;
         cnt          <= HOLD_LOAD;
         cpu_en       <= 1'b0;
         system_reset <= 1'b1;
         busy         <= 1'b1;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         cpu_en       <= cpu_en_nxt;
         system_reset <= system_reset_nxt;
         busy         <= busy_nxt;
      end
   end

endmodule
